// File: rtl/btn_step_pkg.sv
// Shared types and helpers for the button step generator.
// Channel FSM states and counter width helpers.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } ch_state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_step_ch.sv
// One button channel: 2-FF sync, debounce, press/repeat/release FSM.
// The FSM reacts to the debounced next-level so step lines up with level.
import btn_step_pkg::*;

module btn_step_ch #(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_DLY   = 500000,
    parameter int REPEAT_PER   = 100000,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic step,
    output logic released
);

    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam int RW = cnt_w(max_i(REPEAT_DLY, REPEAT_PER));
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_d;
    logic          level_d;
    ch_state_t     state;
    ch_state_t     state_d;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_d;
    logic          step_d;
    logic          rel_d;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after an unbroken run of differing samples.
    always_comb begin
        level_d = level;
        cnt_d   = cnt;
        if (sync2 == level) begin
            cnt_d = '0;
        end else if (cnt == DB_LAST) begin
            level_d = sync2;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt + DW'(1);
        end
    end

    // Debounce state and accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            level <= level_d;
        end
    end

    // FSM state, repeat counter and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rcnt     <= '0;
            step     <= 1'b0;
            released <= 1'b0;
        end else begin
            state    <= state_d;
            rcnt     <= rcnt_d;
            step     <= step_d;
            released <= rel_d;
        end
    end

    // Next-state logic; a release always takes priority over a repeat.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (level_d) state_d = HELD;
            end
            HELD: begin
                if (!level_d) state_d = IDLE;
                else if (REPEAT_EN && rcnt == DLY_LAST) state_d = REPEAT;
            end
            REPEAT: begin
                if (!level_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse and repeat-counter decode for the next cycle.
    always_comb begin
        step_d = 1'b0;
        rel_d  = 1'b0;
        rcnt_d = '0;
        unique case (state)
            IDLE: begin
                step_d = level_d;
            end
            HELD: begin
                if (!level_d) begin
                    rel_d = 1'b1;
                end else if (REPEAT_EN) begin
                    if (rcnt == DLY_LAST) step_d = 1'b1;
                    else rcnt_d = rcnt + RW'(1);
                end
            end
            REPEAT: begin
                if (!level_d) begin
                    rel_d = 1'b1;
                end else if (rcnt == PER_LAST) begin
                    step_d = 1'b1;
                end else begin
                    rcnt_d = rcnt + RW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/btn_step_gen.sv
// Bank of independent button channels producing clk-synchronous step pulses.
// The release pulse port is named released because release is a reserved word.
import btn_step_pkg::*;

module btn_step_gen #(
    parameter int               N_BTN        = 5,
    parameter int               DEBOUNCE_CYC = 20000,
    parameter int               REPEAT_DLY   = 500000,
    parameter int               REPEAT_PER   = 100000,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] step,
    output logic [N_BTN-1:0] released
);

    // One self-contained channel per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_step_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .level    (level[i]),
            .step     (step[i]),
            .released (released[i])
        );
    end

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: directed scenarios plus random button traffic,
// all cycles compared against a run-length / hold-time reference model.
module tb_btn_step_gen;

    localparam int N   = 5;
    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    localparam logic [N-1:0] MASK = 5'b00001;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] level;
    logic [N-1:0] step;
    logic [N-1:0] released;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] m_s1, m_s2, m_lvl, m_step, m_rel;
    int mism [N];
    int held [N];

    btn_step_gen #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (DB),
        .REPEAT_DLY   (DLY),
        .REPEAT_PER   (PER),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .level    (level),
        .step     (step),
        .released (released)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_step = '0; m_rel = '0;
        for (int i = 0; i < N; i++) begin
            mism[i] = 0;
            held[i] = 0;
        end
    endtask

    // Level flips after DB consecutive differing synced samples; a press steps
    // once, then (if enabled) again after DLY held cycles and every PER after.
    task automatic model_step();
        int k;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                mism[i]++;
                if (mism[i] == DB) begin
                    m_lvl[i] = m_s2[i];
                    mism[i]  = 0;
                end
            end else begin
                mism[i] = 0;
            end
            m_s2[i]   = m_s1[i];
            m_s1[i]   = btn_raw[i];
            m_step[i] = 1'b0;
            m_rel[i]  = 1'b0;
            if (m_lvl[i]) begin
                held[i]++;
                k = held[i] - 1;
                if (k == 0) m_step[i] = 1'b1;
                else if (MASK[i] && k >= DLY && (k - DLY) % PER == 0)
                    m_step[i] = 1'b1;
            end else begin
                if (held[i] > 0) m_rel[i] = 1'b1;
                held[i] = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        chk("cycle", {level, step, released}, {m_lvl, m_step, m_rel});
        chk("excl", 32'(|(step & released)), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int first, rfirst, ns, nl;
    int tmr [N];

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        model_reset();
        idle(3);
        chk("rst_state", {level, step, released}, 0);
        reset = 1'b0;
        idle(8);

        // clean press and release on channel 1
        btn_raw[1] = 1'b1;
        first = -1; ns = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (step[1]) begin
                ns++;
                if (first < 0) first = k;
            end
        end
        chk("clean_lat", first, 6);
        chk("clean_steps", ns, 1);
        chk("clean_lvl", level[1], 1);
        btn_raw[1] = 1'b0;
        rfirst = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (released[1] && rfirst < 0) rfirst = k;
        end
        chk("clean_rel", rfirst, 6);

        // bounce on channel 2
        ns = 0;
        for (int k = 0; k < 12; k++) begin
            btn_raw[2] = ((k / 2) % 2 == 0);
            cyc();
            if (step[2] || released[2]) ns++;
        end
        chk("bounce_quiet", ns, 0);
        btn_raw[2] = 1'b1;
        first = -1; ns = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (step[2]) begin
                ns++;
                if (first < 0) first = k;
            end
        end
        chk("bounce_steps", ns, 1);
        chk("bounce_lat", first, 6);
        btn_raw[2] = 1'b0;
        idle(12);

        // glitch on channel 3
        btn_raw[3] = 1'b1;
        nl = 0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) btn_raw[3] = 1'b0;
            cyc();
            if (level[3] || step[3] || released[3]) nl++;
        end
        chk("glitch", nl, 0);

        // auto-repeat on channel 0
        btn_raw[0] = 1'b1;
        ns = 0; rfirst = -1;
        for (int k = 1; k <= 45; k++) begin
            if (k == 31) btn_raw[0] = 1'b0;
            cyc();
            if (step[0]) ns++;
            if (released[0] && rfirst < 0) rfirst = k;
        end
        chk("rep_steps", ns, 8);
        chk("rep_rel", rfirst, 36);
        chk("rep_idle", dut.g_ch[0].u_ch.state, 0);

        // simultaneous press on all channels
        btn_raw = 5'h1F;
        for (int k = 1; k <= 6; k++) cyc();
        chk("simul", step, 5'h1F);
        idle(8);
        btn_raw = '0;
        idle(12);

        // asynchronous reset while held
        btn_raw = 5'h1F;
        idle(12);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst", {level, step, released}, 0);
        idle(2);
        reset = 1'b0;
        first = -1; ns = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (step[1]) begin
                ns++;
                if (first < 0) first = k;
            end
        end
        chk("rst_restep_lat", first, 6);
        chk("rst_restep_n", ns, 1);
        btn_raw = '0;
        idle(12);

        // random traffic with mixed short and long holds
        for (int i = 0; i < N; i++) tmr[i] = $urandom_range(1, 30);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                tmr[i]--;
                if (tmr[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    tmr[i] = ($urandom_range(0, 3) == 0)
                           ? $urandom_range(1, 5) : $urandom_range(3, 45);
                end
            end
            cyc();
        end
        btn_raw = '0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
